// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared types and byte-merge helper for the multi-port memory bank
package mem_bank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fsm_t;

  // Callers zero-extend to these maxima and slice the result back to DW.
  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] merge_bytes(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_NB-1:0] strb
  );
    logic [MAX_DW-1:0] res;
    for (int b = 0; b < MAX_NB; b++) begin
      res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_bank_mp_rd_pipe.sv
// rtl/mem_bank_mp_rd_pipe.sv - per-port read pipeline (RD_LAT stages of valid and data)
module mem_rd_pipe #(
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          oob,
  input  logic          byp,
  input  logic [DW-1:0] raw,
  input  logic [DW-1:0] merged,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          v1;
  logic [DW-1:0] d1;

  // Data only loads on a request so the output holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= req;
      if (req) d1 <= oob ? '0 : (byp ? merged : raw);
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          v2;
    logic [DW-1:0] d2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        d2 <= d1;
      end
    end
    assign valid = v2;
    assign data  = d2;
  end else begin : g_lat1
    assign valid = v1;
    assign data  = d1;
  end

endmodule

// File: rtl/mem_bank_mp.sv
// rtl/mem_bank_mp.sv - flop memory bank: one R/W port, NUM_RD read ports, byte strobes,
// write-first bypass, out-of-range detection and a post-reset clear sweep.
module mem_bank_mp
  import mem_bank_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            AW       = 8,
  parameter int            DEPTH    = 256,
  parameter int            NUM_RD   = 2,
  parameter int            RD_LAT   = 1,
  parameter logic [DW-1:0] INIT_VAL = '0,
  localparam int           NB       = DW / 8,
  localparam int           RP       = (NUM_RD > 0) ? NUM_RD : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [NB-1:0]    wstrb,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    src_data,
  output logic             src_valid,
  input  logic [RP-1:0]    rd_en,
  input  logic [RP*AW-1:0] rd_addr,
  output logic [RP*DW-1:0] rd_data,
  output logic [RP-1:0]    rd_valid,
  output logic             busy,
  output logic             oob_err
);

  localparam int NP = NUM_RD + 1;

  fsm_t          state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [DW-1:0] mem [DEPTH];

  logic          run;
  logic          addr_oob;
  logic          wr_hit;
  logic          any_oob;
  logic [DW-1:0] merged;

  logic [AW-1:0] p_addr [NP];
  logic [DW-1:0] p_raw  [NP];
  logic [DW-1:0] p_data [NP];
  logic [NP-1:0] p_req, p_oob, p_byp, p_valid;

  assign run      = (state == RUN);
  assign busy     = ~run;
  assign addr_oob = (32'(addr) >= 32'(DEPTH));
  assign wr_hit   = run && en && wr && !addr_oob;
  assign merged   = DW'(merge_bytes(MAX_DW'(mem[addr]), MAX_DW'(wdata), MAX_NB'(wstrb)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    if (state == CLEAR) begin
      ptr_nx = ptr + AW'(1);
      if (32'(ptr) == 32'(DEPTH - 1)) begin
        state_nx = RUN;
        ptr_nx   = '0;
      end
    end
  end

  // Storage has no reset; the sweep owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= INIT_VAL;
    else if (wr_hit)    mem[addr] <= merged;
  end

  for (genvar k = 0; k < NP; k++) begin : g_port
    if (k == 0) begin : g_p0
      assign p_addr[k] = addr;
      assign p_req[k]  = run && en && !wr;
    end else begin : g_pn
      assign p_addr[k] = rd_addr[(k-1)*AW +: AW];
      assign p_req[k]  = run && rd_en[k-1];
    end
    assign p_oob[k] = p_req[k] && (32'(p_addr[k]) >= 32'(DEPTH));
    assign p_byp[k] = wr_hit && (p_addr[k] == addr);
    assign p_raw[k] = mem[p_addr[k]];

    mem_rd_pipe #(
      .DW     (DW),
      .RD_LAT (RD_LAT)
    ) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (p_req[k]),
      .oob    (p_oob[k]),
      .byp    (p_byp[k]),
      .raw    (p_raw[k]),
      .merged (merged),
      .valid  (p_valid[k]),
      .data   (p_data[k])
    );
  end

  // Writes count as accesses too, so a dropped write still flags.
  assign any_oob = (run && en && addr_oob) || (|p_oob);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oob_err <= 1'b0;
    else        oob_err <= any_oob;
  end

  assign src_data  = p_data[0];
  assign src_valid = p_valid[0];

  if (NUM_RD > 0) begin : g_rd_out
    for (genvar i = 0; i < NUM_RD; i++) begin : g_out
      assign rd_data[i*DW +: DW] = p_data[i+1];
      assign rd_valid[i]         = p_valid[i+1];
    end
  end else begin : g_no_rd
    assign rd_data  = '0;
    assign rd_valid = '0;
  end

endmodule
